// File: rtl/eth_tx_pkt_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// eth_tx_pkt_arbiter_pkg
//
// Purpose : Shared types and constants for the two-requester Ethernet TX
//           packet arbiter (eth_tx_pkt_arbiter) and its round-robin selector
//           (eth_arb_rr_sel).
//
// Contents:
//   ARB_NUM_PORTS  - number of requesters feeding the arbiter (2)
//   arb_state_e    - arbiter FSM state: IDLE, GNT0, GNT1
//   arb_gnt_state  - maps a requester index to its GNTn state
// ---------------------------------------------------------------------------
package eth_tx_pkt_arbiter_pkg;

    localparam int ARB_NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    // Requester index -> grant state.
    function automatic arb_state_e arb_gnt_state(input logic port);
        return port ? GNT1 : GNT0;
    endfunction

endpackage : eth_tx_pkt_arbiter_pkg

// File: rtl/eth_arb_rr_sel.sv
// ---------------------------------------------------------------------------
// eth_arb_rr_sel
//
// Purpose : Two-way round-robin winner selection. Purely combinational.
//           When both requesters ask, the one that was NOT granted last
//           wins; a lone requester always wins.
//
// Ports:
//   req_i        in   ARB_NUM_PORTS  request vector (bit n = requester n)
//   last_grant_i in   1              requester granted most recently
//   winner_o     out  1              selected requester (valid when any_o)
//   any_o        out  1              at least one request present
// ---------------------------------------------------------------------------
module eth_arb_rr_sel
    import eth_tx_pkt_arbiter_pkg::*;
(
    input  logic [ARB_NUM_PORTS-1:0] req_i,
    input  logic                     last_grant_i,
    output logic                     winner_o,
    output logic                     any_o
);

    always_comb begin
        any_o = |req_i;
        if (&req_i) begin
            winner_o = ~last_grant_i;
        end else begin
            // Only one (or no) requester: requester 1 wins iff it asks.
            winner_o = req_i[1];
        end
    end

endmodule : eth_arb_rr_sel

// File: rtl/eth_tx_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_pkt_arbiter
//
// Purpose : Packet-granular round-robin arbiter merging two streaming
//           requesters onto one Ethernet TX stream. A grant is held from a
//           packet's sop beat until its eop beat is accepted. The granted
//           requester is connected combinationally to the output (zero-cycle
//           latency). Leaving IDLE costs one bubble cycle; a new packet
//           granted on the eop beat of the previous one follows with no
//           bubble. out_almost_full only blocks new grants; an in-flight
//           packet is throttled solely by out_ready.
//
// Parameters:
//   DATA_W   beat data width in bits (default 512)
//   EMPTY_W  empty-byte field width  (default 6)
//
// Ports:
//   Clk              in   1        clock, rising edge
//   Rst_n            in   1        asynchronous active-low reset
//   in0_valid/sop/eop in  1        requester 0 qualifiers
//   in0_data         in   DATA_W   requester 0 payload
//   in0_empty        in   EMPTY_W  requester 0 empty byte count
//   in0_ready        out  1        requester 0 beat accepted (valid&ready)
//   in1_*                          same as in0_* for requester 1
//   out_valid/sop/eop out 1        TX stream qualifiers
//   out_data         out  DATA_W   TX payload
//   out_empty        out  EMPTY_W  TX empty byte count
//   out_ready        in   1        TX beat accepted (valid&ready)
//   out_almost_full  in   1        TX FIFO nearly full; blocks new grants
//   grant_id         out  1        active requester, or last one in IDLE
//   pkt_cnt0/1       out  32       per-requester packet counters
//                                  (present only with ETH_TX_ARB_STATS_EN)
//
// Build option:
//   ETH_TX_ARB_STATS_EN  when defined, adds pkt_cnt0/pkt_cnt1, counting
//                        accepted eop beats per requester (wrapping).
// ---------------------------------------------------------------------------
module eth_tx_pkt_arbiter
    import eth_tx_pkt_arbiter_pkg::*;
#(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6
) (
    input  logic               Clk,
    input  logic               Rst_n,

    input  logic               in0_valid,
    input  logic               in0_sop,
    input  logic               in0_eop,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic [EMPTY_W-1:0] in0_empty,
    output logic               in0_ready,

    input  logic               in1_valid,
    input  logic               in1_sop,
    input  logic               in1_eop,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic [EMPTY_W-1:0] in1_empty,
    output logic               in1_ready,

    output logic               out_valid,
    output logic               out_sop,
    output logic               out_eop,
    output logic [DATA_W-1:0]  out_data,
    output logic [EMPTY_W-1:0] out_empty,
    input  logic               out_ready,
    input  logic               out_almost_full,

    output logic               grant_id
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [31:0]        pkt_cnt0,
    output logic [31:0]        pkt_cnt1
`endif
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;

    logic       rr_last;
    logic       rr_winner;
    logic       rr_any;
    logic       eop_acc;

    // Output mux: the granted requester drives the TX stream directly.
    always_comb begin
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = '0;
        out_empty = '0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        unique case (state_q)
            GNT0: begin
                out_valid = in0_valid;
                out_sop   = in0_sop;
                out_eop   = in0_eop;
                out_data  = in0_data;
                out_empty = in0_empty;
                in0_ready = out_ready;
            end
            GNT1: begin
                out_valid = in1_valid;
                out_sop   = in1_sop;
                out_eop   = in1_eop;
                out_data  = in1_data;
                out_empty = in1_empty;
                in1_ready = out_ready;
            end
            default: ;
        endcase
    end

    // out_valid is 0 in IDLE, so this only fires inside a grant.
    assign eop_acc = out_valid & out_ready & out_eop;

    // On an eop beat the just-finished port counts as "last grant", so it
    // may only continue when the other requester is idle.
    always_comb begin
        unique case (state_q)
            GNT0:    rr_last = 1'b0;
            GNT1:    rr_last = 1'b1;
            default: rr_last = last_grant_q;
        endcase
    end

    eth_arb_rr_sel u_rr_sel (
        .req_i        ({in1_valid, in0_valid}),
        .last_grant_i (rr_last),
        .winner_o     (rr_winner),
        .any_o        (rr_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (!out_almost_full && rr_any) begin
                    state_d = arb_gnt_state(rr_winner);
                end
            end
            GNT0, GNT1: begin
                if (eop_acc) begin
                    last_grant_d = (state_q == GNT1);
                    if (!out_almost_full && rr_any) begin
                        state_d = arb_gnt_state(rr_winner);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        unique case (state_q)
            GNT0:    grant_id = 1'b0;
            GNT1:    grant_id = 1'b1;
            default: grant_id = last_grant_q;
        endcase
    end

`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] cnt0_q;
    logic [31:0] cnt1_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (eop_acc) begin
            if (state_q == GNT0) begin
                cnt0_q <= cnt0_q + 32'd1;
            end
            if (state_q == GNT1) begin
                cnt1_q <= cnt1_q + 32'd1;
            end
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`endif

endmodule : eth_tx_pkt_arbiter

// File: tb/tb_eth_tx_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_pkt_arbiter
//
// Directed bench for eth_tx_pkt_arbiter. Two simple packet sources feed the
// requester ports; each source walks through a configured number of packets
// of a fixed length, advancing one beat per accepted handshake. Expected
// output values come from the source bookkeeping and hand-derived timelines.
// ---------------------------------------------------------------------------
module tb_eth_tx_pkt_arbiter;

    localparam int DW = 32;
    localparam int EW = 6;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          in0_valid, in0_sop, in0_eop, in0_ready;
    logic [DW-1:0] in0_data;
    logic [EW-1:0] in0_empty;
    logic          in1_valid, in1_sop, in1_eop, in1_ready;
    logic [DW-1:0] in1_data;
    logic [EW-1:0] in1_empty;
    logic          out_valid, out_sop, out_eop;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_empty;
    logic          out_ready;
    logic          out_almost_full;
    logic          grant_id;
`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0]   pkt_cnt0, pkt_cnt1;
`endif

    eth_tx_pkt_arbiter #(.DATA_W(DW), .EMPTY_W(EW)) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .in0_valid       (in0_valid),
        .in0_sop         (in0_sop),
        .in0_eop         (in0_eop),
        .in0_data        (in0_data),
        .in0_empty       (in0_empty),
        .in0_ready       (in0_ready),
        .in1_valid       (in1_valid),
        .in1_sop         (in1_sop),
        .in1_eop         (in1_eop),
        .in1_data        (in1_data),
        .in1_empty       (in1_empty),
        .in1_ready       (in1_ready),
        .out_valid       (out_valid),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .out_data        (out_data),
        .out_empty       (out_empty),
        .out_ready       (out_ready),
        .out_almost_full (out_almost_full),
        .grant_id        (grant_id)
`ifdef ETH_TX_ARB_STATS_EN
        ,
        .pkt_cnt0        (pkt_cnt0),
        .pkt_cnt1        (pkt_cnt1)
`endif
    );

    always #5 Clk = ~Clk;

    int   n_tests = 0;
    int   n_fail  = 0;

    int   s_len  [2];
    int   s_pkts [2];
    int   s_done [2];
    int   s_beat [2];
    logic sop_force0;
    logic a0, a1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int p, input int k, input int b);
        return {8'(p + 1), 8'(k), 16'(b)};
    endfunction

    task automatic drive();
        in0_valid = (s_done[0] < s_pkts[0]);
        in0_sop   = (s_beat[0] == 0) || sop_force0;
        in0_eop   = (s_beat[0] == s_len[0] - 1);
        in0_data  = pat(0, s_done[0], s_beat[0]);
        in0_empty = 6'(s_beat[0]);
        in1_valid = (s_done[1] < s_pkts[1]);
        in1_sop   = (s_beat[1] == 0);
        in1_eop   = (s_beat[1] == s_len[1] - 1);
        in1_data  = pat(1, s_done[1], s_beat[1]);
        in1_empty = 6'(s_beat[1]);
    endtask

    task automatic adv(input int p);
        if (s_beat[p] == s_len[p] - 1) begin
            s_beat[p] = 0;
            s_done[p]++;
        end else begin
            s_beat[p]++;
        end
    endtask

    // Capture handshakes before the edge, then advance the sources.
    task automatic tick();
        a0 = in0_valid & in0_ready;
        a1 = in1_valid & in1_ready;
        @(posedge Clk);
        #1;
        if (a0) adv(0);
        if (a1) adv(1);
        drive();
        #1;
    endtask

    task automatic do_reset(input int l0, input int p0, input int l1, input int p1);
        Rst_n = 1'b0;
        s_len[0] = l0; s_pkts[0] = p0; s_done[0] = 0; s_beat[0] = 0;
        s_len[1] = l1; s_pkts[1] = p1; s_done[1] = 0; s_beat[1] = 0;
        sop_force0      = 1'b0;
        out_ready       = 1'b1;
        out_almost_full = 1'b0;
        drive();
        @(posedge Clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in0_ready", 64'(in0_ready), 64'(0));
        chk("rst_in1_ready", 64'(in1_ready), 64'(0));
        chk("rst_grant_id",  64'(grant_id),  64'(1));
`ifdef ETH_TX_ARB_STATS_EN
        chk("rst_cnt0", 64'(pkt_cnt0), 64'(0));
        chk("rst_cnt1", 64'(pkt_cnt1), 64'(0));
`endif
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int ep;
        int viol;

        // Both requesters, two 3-beat packets each: grants 0,1,0,1.
        do_reset(3, 2, 3, 2);
        chk("A_bubble", 64'(out_valid), 64'(0));
        for (int c = 1; c <= 12; c++) begin
            tick();
            ep = ((c - 1) / 3) % 2;
            chk("A_valid", 64'(out_valid), 64'(1));
            chk("A_grant", 64'(grant_id),  64'(ep));
            chk("A_data",  64'(out_data),  64'(pat(ep, s_done[ep], s_beat[ep])));
            chk("A_sop",   64'(out_sop),   64'(s_beat[ep] == 0));
        end
        tick();
        chk("A_drained", 64'(out_valid), 64'(0));
`ifdef ETH_TX_ARB_STATS_EN
        chk("A_cnt0", 64'(pkt_cnt0), 64'(2));
        chk("A_cnt1", 64'(pkt_cnt1), 64'(2));
`endif

        // Only requester 1, two single-beat packets back to back.
        do_reset(1, 0, 1, 2);
        chk("B_bubble", 64'(out_valid), 64'(0));
        tick();
        chk("B_v1",     64'(out_valid), 64'(1));
        chk("B_g1",     64'(grant_id),  64'(1));
        chk("B_se1",    64'({out_sop, out_eop}), 64'(3));
        chk("B_d1",     64'(out_data),  64'(pat(1, 0, 0)));
        chk("B_r0",     64'(in0_ready), 64'(0));
        chk("B_r1",     64'(in1_ready), 64'(1));
        tick();
        chk("B_v2",     64'(out_valid), 64'(1));
        chk("B_g2",     64'(grant_id),  64'(1));
        chk("B_d2",     64'(out_data),  64'(pat(1, 1, 0)));
        tick();
        chk("B_done",   64'(out_valid), 64'(0));

        // Almost-full in IDLE withholds the grant.
        do_reset(1, 1, 1, 0);
        out_almost_full = 1'b1;
        #1;
        viol = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid || in0_ready || grant_id != 1'b1) viol++;
        end
        chk("C_held", 64'(viol), 64'(0));
        out_almost_full = 1'b0;
        #1;
        chk("C_still_idle", 64'(out_valid), 64'(0));
        tick();
        chk("C_valid", 64'(out_valid), 64'(1));
        chk("C_grant", 64'(grant_id),  64'(0));
        chk("C_ready", 64'(in0_ready), 64'(1));

        // Almost-full rises mid-packet: packet completes, next grant waits.
        do_reset(4, 2, 1, 0);
        chk("D_bubble", 64'(out_valid), 64'(0));
        tick();
        chk("D_b0", 64'(out_data), 64'(pat(0, 0, 0)));
        tick();
        out_almost_full = 1'b1;
        #1;
        chk("D_b1_valid", 64'(out_valid), 64'(1));
        chk("D_b1_ready", 64'(in0_ready), 64'(1));
        tick();
        chk("D_b2", 64'(out_data), 64'(pat(0, 0, 2)));
        tick();
        chk("D_b3_eop",  64'(out_eop),  64'(1));
        chk("D_b3_data", 64'(out_data), 64'(pat(0, 0, 3)));
        viol = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_valid || in0_ready) viol++;
        end
        chk("D_held", 64'(viol), 64'(0));
        out_almost_full = 1'b0;
        #1;
        chk("D_still_idle", 64'(out_valid), 64'(0));
        tick();
        chk("D_resume_sop",  64'(out_sop),  64'(1));
        chk("D_resume_data", 64'(out_data), 64'(pat(0, 1, 0)));

        // out_ready toggling; requester 1 waiting; stray sop on beat 2.
        do_reset(4, 1, 2, 1);
        chk("E_bubble", 64'(out_valid), 64'(0));
        for (int c = 1; c <= 7; c++) begin
            tick();
            out_ready  = (c % 2 == 1);
            sop_force0 = (s_beat[0] == 2);
            drive();
            #1;
            chk("E_grant",  64'(grant_id),  64'(0));
            chk("E_data",   64'(out_data),  64'(pat(0, 0, s_beat[0])));
            chk("E_sop",    64'(out_sop),   64'(s_beat[0] == 0 || s_beat[0] == 2));
            chk("E_rdy0",   64'(in0_ready), 64'(c % 2 == 1));
            chk("E_rdy1",   64'(in1_ready), 64'(0));
        end
        chk("E_eop_beat", 64'(s_beat[0]), 64'(3));
        tick();
        chk("E_next_grant", 64'(grant_id), 64'(1));
        chk("E_next_sop",   64'(out_sop),  64'(1));

        // Asynchronous reset mid-packet.
        do_reset(3, 2, 3, 2);
        tick();
        tick();
        chk("F_mid_valid", 64'(out_valid), 64'(1));
        #1;
        Rst_n = 1'b0;
        #1;
        chk("F_rst_valid", 64'(out_valid), 64'(0));
        chk("F_rst_rdy0",  64'(in0_ready), 64'(0));
        chk("F_rst_rdy1",  64'(in1_ready), 64'(0));
        chk("F_rst_grant", 64'(grant_id),  64'(1));
        s_beat[0] = 0;
        drive();
        @(posedge Clk);
        #1;
        chk("F_held_valid", 64'(out_valid), 64'(0));
`ifdef ETH_TX_ARB_STATS_EN
        chk("F_cnt0", 64'(pkt_cnt0), 64'(0));
`endif
        Rst_n = 1'b1;
        #1;
        chk("F_bubble", 64'(out_valid), 64'(0));
        tick();
        chk("F_grant", 64'(grant_id), 64'(0));
        chk("F_sop",   64'(out_sop),  64'(1));
        chk("F_data",  64'(out_data), 64'(pat(0, 0, 0)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_eth_tx_pkt_arbiter
